alu_seq: RTL and testbench

Sequential execution unit that consumes the 4-bit ALU control code produced by the ALU controller and performs the selected operation on two operands. It sits in the execute stage, downstream of the ALU controller. Logic ops, add/sub and set-less-than complete in one cycle. A new iterative multiply code takes WIDTH cycles. All results, flags and completion pulses are registered, with a start/busy/done handshake toward the datapath control.

---
 rtl/alu_seq.sv | 181 ++++++++++++++++++
 tb/tb_alu_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- sequential execute-stage ALU
//
// Runs the operation selected by the 4-bit ALU control code on two operands.
// AND/OR/ADD/SUB/SLT/NOR and unknown codes (NOP) finish in one cycle. MUL is
// an iterative shift-add that takes WIDTH cycles. Every result, flag and
// completion pulse is registered.
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   start_i     request, accepted only while busy_o = 0
//   ALUCtrl_i   op code: 0 AND, 1 OR, 2 ADD, 3 MUL, 6 SUB, 7 SLT, 12 NOR,
//               anything else NOP
//   src1_i      operand A, sampled at acceptance
//   src2_i      operand B, sampled at acceptance
//   busy_o      high while a MUL is iterating
//   done_o      one-cycle pulse when result_o/zero_o/overflow_o update
//   result_o    last completed result
//   zero_o      result_o == 0
//   overflow_o  signed overflow of the last ADD/SUB, else 0
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic             w_single;
    logic             w_mul_start;
    logic             w_mul_done;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_add_ov;
    logic             w_sub_ov;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ov;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_acc_next;

    // Single-cycle datapath
    assign w_sum    = src1_i + src2_i;
    assign w_diff   = src1_i - src2_i;
    assign w_add_ov = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                      (w_sum[WIDTH-1]  != src1_i[WIDTH-1]);
    assign w_sub_ov = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                      (w_diff[WIDTH-1] != src1_i[WIDTH-1]);

    always_comb begin
        w_alu_res = '0;
        w_alu_ov  = 1'b0;
        case (ALUCtrl_i)
            4'd0:    w_alu_res = src1_i & src2_i;
            4'd1:    w_alu_res = src1_i | src2_i;
            4'd2: begin
                w_alu_res = w_sum;
                w_alu_ov  = w_add_ov;
            end
            4'd6: begin
                w_alu_res = w_diff;
                w_alu_ov  = w_sub_ov;
            end
            // Sign of the difference corrected by overflow gives the true
            // signed less-than even when A - B wraps.
            4'd7:    w_alu_res = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1] ^ w_sub_ov};
            4'd12:   w_alu_res = ~(src1_i | src2_i);
            default: w_alu_res = '0;
        endcase
    end

    // Multiply step: add the shifted multiplicand when the current
    // multiplier LSB is set; only the low WIDTH bits are kept.
    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_addend;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and step control
    always_comb begin
        w_next      = r_state;
        w_single    = 1'b0;
        w_mul_start = 1'b0;
        w_mul_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (ALUCtrl_i == 4'd3) begin
                        w_mul_start = 1'b1;
                        w_next      = S_MUL;
                    end else begin
                        w_single = 1'b1;
                    end
                end
            end
            S_MUL: begin
                // The edge that consumes the last multiplier bit also
                // publishes the product.
                if (r_cnt == LAST_IT) begin
                    w_mul_done = 1'b1;
                    w_next     = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            overflow_o <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= w_single | w_mul_done;

            if (w_mul_start) begin
                r_mcand  <= src1_i;
                r_mplier <= src2_i;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (r_state == S_MUL) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CNT_W'(1);
            end

            if (w_single) begin
                result_o   <= w_alu_res;
                zero_o     <= (w_alu_res == '0);
                overflow_o <= w_alu_ov;
            end else if (w_mul_done) begin
                result_o   <= w_acc_next;
                zero_o     <= (w_acc_next == '0);
                overflow_o <= 1'b0;
            end
        end
    end

    assign busy_o = (r_state == S_MUL);

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH = 32)
// Directed cases followed by randomized operations compared against an
// arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   code;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .ALUCtrl_i  (code),
        .src1_i     (src1),
        .src2_i     (src2),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result),
        .zero_o     (zero),
        .overflow_o (ovf)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: plain wide arithmetic on the operation definitions.
    task automatic model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic ov);
        longint       s;
        logic [63:0]  p;
        r  = '0;
        ov = 1'b0;
        case (c)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin
                s  = longint'($signed(a)) + longint'($signed(b));
                r  = s[W-1:0];
                ov = (s != longint'($signed(r)));
            end
            4'd3: begin
                p = {32'b0, a} * {32'b0, b};
                r = p[W-1:0];
            end
            4'd6: begin
                s  = longint'($signed(a)) - longint'($signed(b));
                r  = s[W-1:0];
                ov = (s != longint'($signed(r)));
            end
            4'd7:  r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'd12: r = ~(a | b);
            default: r = '0;
        endcase
    endtask

    // Issue one request from just after a rising edge; returns just after
    // the edge whose cycle shows done_o. When poke is set, an ADD start is
    // attempted in the middle of a MUL.
    task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke);
        logic [W-1:0] er;
        logic         eo;
        model(c, a, b, er, eo);
        start = 1'b1;
        code  = c;
        src1  = a;
        src2  = b;
        @(posedge clk); #1;
        start = 1'b0;
        if (c == 4'd3) begin
            for (int i = 0; i < W; i++) begin
                chk("mul_busy", W'(busy), W'(1));
                chk("mul_no_done", W'(done), W'(0));
                src1  = $urandom;
                src2  = $urandom;
                code  = (poke && i == 5) ? 4'd2 : 4'($urandom);
                start = (poke && i == 5);
                @(posedge clk); #1;
            end
            start = 1'b0;
        end
        chk("done", W'(done), W'(1));
        chk("busy_after", W'(busy), W'(0));
        chk("result", result, er);
        chk("zero", W'(zero), W'(er == '0));
        chk("overflow", W'(ovf), W'(eo));
    endtask

    task automatic idle_chk();
        @(posedge clk); #1;
        chk("done_idle", W'(done), W'(0));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, expected end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] c;
        rst   = 1'b1;
        start = 1'b0;
        code  = '0;
        src1  = '0;
        src2  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", result, W'(0));
        chk("rst_zero", W'(zero), W'(0));
        chk("rst_ovf", W'(ovf), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // ADD overflow at the positive limit
        run_op(4'd2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        chk("add_res", result, 32'h8000_0000);
        chk("add_ovf", W'(ovf), W'(1));
        idle_chk();

        // SUB to zero, then SLT at the extremes, back to back
        run_op(4'd6, 32'h0000_1234, 32'h0000_1234, 1'b0);
        chk("sub_zero", W'(zero), W'(1));
        run_op(4'd7, 32'h8000_0000, 32'h0000_0001, 1'b0);
        chk("slt_min", result, 32'h0000_0001);
        run_op(4'd7, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("slt_max", result, 32'h0000_0000);
        idle_chk();

        // MUL with an ignored start during busy
        run_op(4'd3, 32'h0001_0003, 32'h0000_0005, 1'b1);
        chk("mul_res", result, 32'h0005_000F);
        idle_chk();

        // MUL truncation, then AND issued in the done cycle
        run_op(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("mul_trunc", result, 32'h0000_0001);
        run_op(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        chk("and_b2b", result, 32'hF000_F000);
        idle_chk();

        // Reset in the middle of a MUL
        start = 1'b1;
        code  = 4'd3;
        src1  = 32'h1234_5678;
        src2  = 32'h9ABC_DEF1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_busy", W'(busy), W'(0));
        chk("midrst_done", W'(done), W'(0));
        chk("midrst_result", result, W'(0));
        chk("midrst_zero", W'(zero), W'(0));
        chk("midrst_ovf", W'(ovf), W'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < W + 4; i++) idle_chk();
        run_op(4'd1, 32'h0000_0001, 32'h0000_0002, 1'b0);
        chk("or_after_rst", result, 32'h0000_0003);

        // Reset asserted during a done cycle
        run_op(4'd2, 32'h0000_0005, 32'h0000_0006, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("donerst_done", W'(done), W'(0));
        chk("donerst_result", result, W'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // NOP and NOR corners
        run_op(4'd5, W'($urandom), W'($urandom), 1'b0);
        chk("nop_res", result, W'(0));
        chk("nop_zero", W'(zero), W'(1));
        run_op(4'd12, 32'h0, 32'h0, 1'b0);
        chk("nor_res", result, 32'hFFFF_FFFF);
        idle_chk();

        // Randomized operations
        for (int n = 0; n < 80; n++) begin
            c = 4'($urandom_range(0, 15));
            if (c == 4'd3 && $urandom_range(0, 3) != 0) c = 4'd7;
            run_op(c, pick(), pick(), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_chk();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
